// File: rtl/soc_sysid_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : soc_sysid_pkg
//  Purpose  : Shared constants for the second-generation system-ID block.
//             Holds the register word map, the CTRL/STATUS bit positions,
//             the CAPS field layout and a byte-lane merge helper.
//  Revision : 1.0  initial release
// ============================================================================
package soc_sysid_pkg;

  // Register word addresses
  localparam logic [3:0] ADDR_ID        = 4'd0;
  localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
  localparam logic [3:0] ADDR_VERSION   = 4'd2;
  localparam logic [3:0] ADDR_CAPS      = 4'd3;
  localparam logic [3:0] ADDR_UPTIME_LO = 4'd4;
  localparam logic [3:0] ADDR_UPTIME_HI = 4'd5;
  localparam logic [3:0] ADDR_CTRL      = 4'd6;
  localparam logic [3:0] ADDR_STATUS    = 4'd7;
  localparam logic [3:0] ADDR_SCRATCH0  = 4'd8;

  // CTRL bit indices
  localparam int CTRL_CNT_EN  = 0;
  localparam int CTRL_CNT_CLR = 1;
  localparam int CTRL_HB_EN   = 2;

  // STATUS bit index
  localparam int STAT_OVF = 0;

  // CAPS field positions
  localparam int CAPS_NSCR_LSB = 0;
  localparam int CAPS_NSCR_W   = 4;
  localparam int CAPS_CNTW_LSB = 8;
  localparam int CAPS_CNTW_W   = 7;

  // CTRL reset value (counter and heartbeat enabled) and the bits that are
  // actually stored; cnt_clr is a write-only strobe and never stored.
  localparam logic [31:0] CTRL_RESET   = 32'h0000_0005;
  localparam logic [31:0] CTRL_STORED  = 32'h0000_0005;

  // Replace the bytes of old_val selected by be with those of new_val.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/soc_sysid_uptime.sv
`default_nettype none
// ============================================================================
//  Module   : soc_sysid_uptime
//  Purpose  : Free-running uptime counter with clear/enable, wrap pulse,
//             heartbeat prescaler and heartbeat toggle flop.
//  Ports    : clock, reset_n       - clock, async active-low reset
//             cnt_en, cnt_clr      - count enable, synchronous clear strobe
//             hb_en                - heartbeat enable
//             count [CNT_W]        - live counter value
//             ovf_pulse            - high in the cycle whose edge wraps count
//             heartbeat            - square-wave liveness output
//  Revision : 1.0  initial release
// ============================================================================
module soc_sysid_uptime
  import soc_sysid_pkg::*;
#(
  parameter int CNT_W         = 64,
  parameter int HEARTBEAT_DIV = 50000000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cnt_en,
  input  logic             cnt_clr,
  input  logic             hb_en,
  output logic [CNT_W-1:0] count,
  output logic             ovf_pulse,
  output logic             heartbeat
);

  localparam int              PRE_W    = (HEARTBEAT_DIV > 2) ? $clog2(HEARTBEAT_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(HEARTBEAT_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             hb_q, hb_d;

  // Clear beats increment; wrap is flagged only when an increment happens.
  always_comb begin
    cnt_d     = cnt_q;
    ovf_pulse = 1'b0;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_en) begin
      cnt_d     = cnt_q + CNT_W'(1);
      ovf_pulse = &cnt_q;
    end
  end

  // Heartbeat toggles on the edge where the prescaler rolls back to 0.
  always_comb begin
    presc_d = '0;
    hb_d    = hb_q;
    if (hb_en) begin
      if (presc_q == PRE_LAST) begin
        presc_d = '0;
        hb_d    = ~hb_q;
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      presc_q <= '0;
      hb_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      hb_q    <= hb_d;
    end
  end

  assign count     = cnt_q;
  assign heartbeat = hb_q;

endmodule
`default_nettype wire

// File: rtl/soc_sysid_ext.sv
`default_nettype none
// ============================================================================
//  Module   : soc_sysid_ext
//  Purpose  : Avalon-MM system-ID slave: RO identification words, uptime
//             counter with coherent 64-bit snapshot, CTRL/STATUS, scratch
//             registers and a heartbeat output.
//  Ports    : clock, reset_n       - clock, async active-low reset
//             address[3:0]         - word address
//             read, write          - bus strobes (write wins when both set)
//             writedata, byteenable- write data and byte lanes
//             readdata             - registered read data (latency 1)
//             readdatavalid        - qualifies readdata
//             heartbeat            - liveness square wave
//  Revision : 1.0  initial release
// ============================================================================
module soc_sysid_ext
  import soc_sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE      = 32'hA5A5_0001,
  parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
  parameter logic [31:0] VERSION       = 32'h0001_0000,
  parameter int          NUM_SCRATCH   = 4,
  parameter int          CNT_W         = 64,
  parameter int          HEARTBEAT_DIV = 50000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        heartbeat
);

  logic [31:0] ctrl_q, ctrl_d;
  logic        ovf_q, ovf_d;
  logic [31:0] snap_q, snap_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rdv_q, rdv_d;
  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [31:0] scratch_d [NUM_SCRATCH];

  logic [CNT_W-1:0] count;
  logic             ovf_pulse;
  logic             rd_fire;
  logic             cnt_clr;
  logic [31:0]      caps;
  logic [31:0]      cnt_hi_ext;
  logic [31:0]      rd_mux;

  // A read colliding with a write is dropped entirely.
  assign rd_fire = read && !write;

  // Clear strobe acts at the edge ending the CTRL write; it is never stored.
  assign cnt_clr = write && (address == ADDR_CTRL) && byteenable[0]
                   && writedata[CTRL_CNT_CLR];

  soc_sysid_uptime #(
    .CNT_W         (CNT_W),
    .HEARTBEAT_DIV (HEARTBEAT_DIV)
  ) u_uptime (
    .clock     (clock),
    .reset_n   (reset_n),
    .cnt_en    (ctrl_q[CTRL_CNT_EN]),
    .cnt_clr   (cnt_clr),
    .hb_en     (ctrl_q[CTRL_HB_EN]),
    .count     (count),
    .ovf_pulse (ovf_pulse),
    .heartbeat (heartbeat)
  );

  always_comb begin
    caps = '0;
    caps[CAPS_NSCR_LSB +: CAPS_NSCR_W] = CAPS_NSCR_W'(NUM_SCRATCH);
    caps[CAPS_CNTW_LSB +: CAPS_CNTW_W] = CAPS_CNTW_W'(CNT_W);
  end

  // Upper counter bits, zero-extended to a full word.
  always_comb begin
    cnt_hi_ext = '0;
    cnt_hi_ext[CNT_W-33:0] = count[CNT_W-1:32];
  end

  // Register writes
  always_comb begin
    ctrl_d = ctrl_q;
    if (write && (address == ADDR_CTRL)) begin
      ctrl_d = be_merge(ctrl_q, writedata, byteenable) & CTRL_STORED;
    end

    // Overflow set is applied after the clear so that it wins.
    ovf_d = ovf_q;
    if (write && (address == ADDR_STATUS) && byteenable[0] && writedata[STAT_OVF]) begin
      ovf_d = 1'b0;
    end
    if (ovf_pulse) begin
      ovf_d = 1'b1;
    end

    for (int i = 0; i < NUM_SCRATCH; i++) begin
      scratch_d[i] = scratch_q[i];
      if (write && (int'(address) == int'(ADDR_SCRATCH0) + i)) begin
        scratch_d[i] = be_merge(scratch_q[i], writedata, byteenable);
      end
    end
  end

  // Read mux
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_ID:        rd_mux = ID_VALUE;
      ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
      ADDR_VERSION:   rd_mux = VERSION;
      ADDR_CAPS:      rd_mux = caps;
      ADDR_UPTIME_LO: rd_mux = count[31:0];
      ADDR_UPTIME_HI: rd_mux = snap_q;
      ADDR_CTRL:      rd_mux = ctrl_q;
      ADDR_STATUS:    rd_mux = {31'd0, ovf_q};
      default:        rd_mux = '0;
    endcase
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (int'(address) == int'(ADDR_SCRATCH0) + i) rd_mux = scratch_q[i];
    end
  end

  // Read pipeline; reading the low uptime word freezes the upper word so a
  // following read of UPTIME_HI returns a coherent 64-bit pair.
  always_comb begin
    rdv_d      = rd_fire;
    readdata_d = rd_fire ? rd_mux : readdata_q;
    snap_d     = snap_q;
    if (rd_fire && (address == ADDR_UPTIME_LO)) begin
      snap_d = cnt_hi_ext;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= CTRL_RESET;
      ovf_q      <= 1'b0;
      snap_q     <= '0;
      readdata_q <= '0;
      rdv_q      <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      snap_q     <= snap_d;
      readdata_q <= readdata_d;
      rdv_q      <= rdv_d;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= scratch_d[i];
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_sysid_ext.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_soc_sysid_ext
//  Purpose  : Directed self-checking bench for soc_sysid_ext.
//  Revision : 1.0  initial release
// ============================================================================
module tb_soc_sysid_ext;

  logic        clock      = 1'b0;
  logic        reset_n    = 1'b0;
  logic [3:0]  address    = '0;
  logic        read       = 1'b0;
  logic        write      = 1'b0;
  logic [31:0] writedata  = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        heartbeat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  soc_sysid_ext #(
    .ID_VALUE      (32'hA5A5_0001),
    .TIMESTAMP     (32'h0000_0000),
    .VERSION       (32'h0001_0000),
    .NUM_SCRATCH   (4),
    .CNT_W         (64),
    .HEARTBEAT_DIV (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .heartbeat     (heartbeat)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled at the
  // next falling edge, half a period after the rising edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    @(negedge clock);
    write      = 1'b0;
    byteenable = '0;
  endtask

  task automatic bus_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
    address = a;
    read    = 1'b1;
    @(negedge clock);
    read    = 1'b0;
    check({tag, " rdv"}, 64'(readdatavalid), 64'd1);
    check(tag, 64'(readdata), 64'(exp));
  endtask

  logic [31:0] id_exp [4];

  initial begin
    id_exp = '{32'hA5A5_0001, 32'h0000_0000, 32'h0001_0000, 32'h0000_4004};

    // Reset state
    repeat (2) @(negedge clock);
    check("rst readdata", 64'(readdata), 64'd0);
    check("rst rdv", 64'(readdatavalid), 64'd0);
    check("rst heartbeat", 64'(heartbeat), 64'd0);
    reset_n = 1'b1;

    // Back-to-back identification reads
    read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      address = 4'(i);
      @(negedge clock);
      check($sformatf("id word %0d rdv", i), 64'(readdatavalid), 64'd1);
      check($sformatf("id word %0d", i), 64'(readdata), 64'(id_exp[i]));
    end
    read = 1'b0;
    @(negedge clock);
    check("idle rdv low", 64'(readdatavalid), 64'd0);
    check("idle readdata hold", 64'(readdata), 64'h0000_4004);
    bus_read("unmapped 12", 4'd12, 32'h0);
    bus_read("ctrl reset", 4'd6, 32'h5);
    bus_read("status reset", 4'd7, 32'h0);

    // Scratch byte lanes, scratch range end, RO and unmapped writes
    bus_write(4'd8, 32'hDEAD_BEEF, 4'b0101);
    bus_read("scratch0 be", 4'd8, 32'h00AD_00EF);
    bus_write(4'd11, 32'h1234_5678, 4'hF);
    bus_read("scratch3", 4'd11, 32'h1234_5678);
    bus_write(4'd12, 32'hFFFF_FFFF, 4'hF);
    bus_read("past scratch", 4'd12, 32'h0);
    bus_write(4'd0, 32'hFFFF_FFFF, 4'hF);
    bus_read("id after write", 4'd0, 32'hA5A5_0001);

    // Coherent uptime snapshot
    bus_write(4'd6, 32'h0, 4'hF);
    force dut.u_uptime.cnt_q = 64'h0000_0001_FFFF_FFFE;
    @(negedge clock);
    release dut.u_uptime.cnt_q;
    bus_write(4'd6, 32'h1, 4'hF);
    bus_read("uptime lo", 4'd4, 32'hFFFF_FFFE);
    repeat (2) @(negedge clock);
    bus_read("uptime hi snapshot", 4'd5, 32'h0000_0001);
    bus_read("uptime lo 2", 4'd4, 32'h0000_0002);
    bus_read("uptime hi 2", 4'd5, 32'h0000_0002);

    // Wrap sets overflow; set beats a same-cycle W1C
    bus_write(4'd6, 32'h0, 4'hF);
    force dut.u_uptime.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clock);
    release dut.u_uptime.cnt_q;
    bus_write(4'd6, 32'h1, 4'hF);
    bus_write(4'd7, 32'h1, 4'h1);
    bus_read("wrap to zero", 4'd4, 32'h0);
    bus_read("status set wins", 4'd7, 32'h1);
    bus_read("status sticky", 4'd7, 32'h1);
    bus_write(4'd7, 32'h1, 4'h1);
    bus_read("status w1c", 4'd7, 32'h0);

    // Clear while running
    bus_write(4'd6, 32'h3, 4'hF);
    bus_read("clear lo", 4'd4, 32'h0);
    bus_read("ctrl clr reads 0", 4'd6, 32'h1);
    bus_read("count resumes", 4'd4, 32'h2);

    // Reset while a readdatavalid is pending
    address = 4'd0;
    read    = 1'b1;
    @(posedge clock);
    #1;
    read = 1'b0;
    check("pending rdv", 64'(readdatavalid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("reset drops rdv", 64'(readdatavalid), 64'd0);
    check("reset clears readdata", 64'(readdata), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Heartbeat: toggles every 4 cycles after reset
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      check($sformatf("heartbeat cycle %0d", k), 64'(heartbeat), 64'((k / 4) % 2));
    end
    bus_write(4'd6, 32'h1, 4'h1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check($sformatf("heartbeat frozen %0d", k), 64'(heartbeat), 64'd1);
    end

    // Read and write in the same cycle: write done, read dropped
    address    = 4'd6;
    writedata  = 32'h5;
    byteenable = 4'hF;
    read       = 1'b1;
    write      = 1'b1;
    @(negedge clock);
    read       = 1'b0;
    write      = 1'b0;
    byteenable = '0;
    check("collide no rdv", 64'(readdatavalid), 64'd0);
    check("collide readdata hold", 64'(readdata), 64'd0);
    bus_read("collide write done", 4'd6, 32'h5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
